// File: rtl/hilo_div_ctrl_pkg.sv
// Shared encodings for the HI/LO divide sequencer: request opcodes and FSM states.
package hilo_div_ctrl_pkg;

  typedef logic [1:0] op_t;
  typedef logic [1:0] state_t;

  localparam op_t OP_DIV  = 2'b00;
  localparam op_t OP_DIVU = 2'b01;
  localparam op_t OP_MTHI = 2'b10;
  localparam op_t OP_MTLO = 2'b11;

  localparam state_t ST_IDLE  = 2'b00;
  localparam state_t ST_ISSUE = 2'b01;
  localparam state_t ST_WAIT  = 2'b10;
  localparam state_t ST_DRAIN = 2'b11;

  // Moves have bit 1 set; divides use bit 0 as the unsigned flag.
  function automatic logic op_is_move(input op_t op);
    return op[1];
  endfunction

endpackage

// File: rtl/hilo_div_ctrl_if.sv
// Execute-stage request bus plus divider start/done bus; slave is the sequencer side.
interface hilo_div_ctrl_if #(
  parameter int DATA_BITS = 32
) ();
  import hilo_div_ctrl_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  op_t                  req_op;
  logic [DATA_BITS-1:0] req_a;
  logic [DATA_BITS-1:0] req_b;
  logic                 cancel;
  logic                 busy;
  logic                 res_valid;
  logic                 dbz;
  logic [DATA_BITS-1:0] hi;
  logic [DATA_BITS-1:0] lo;

  logic                 div_en;
  logic                 div_sign;
  logic [DATA_BITS-1:0] div_dividend;
  logic [DATA_BITS-1:0] div_divisor;
  logic                 div_done;
  logic [DATA_BITS-1:0] div_quotient;
  logic [DATA_BITS-1:0] div_remainder;

  modport master (
    output req_valid, req_op, req_a, req_b, cancel,
    input  req_ready, busy, res_valid, dbz, hi, lo,
    input  div_en, div_sign, div_dividend, div_divisor,
    output div_done, div_quotient, div_remainder
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, cancel,
    output req_ready, busy, res_valid, dbz, hi, lo,
    output div_en, div_sign, div_dividend, div_divisor,
    input  div_done, div_quotient, div_remainder
  );

endinterface

// File: rtl/hilo_div_ctrl.sv
// Divide/move sequencer owning HI/LO: divides commit DATA_BITS+3 cycles after accept,
// moves and divide-by-zero next cycle; req_ready drops while any divide is outstanding or on cancel.
module hilo_div_ctrl
  import hilo_div_ctrl_pkg::*;
#(
  parameter int DATA_BITS = 32
) (
  input  logic             clk,
  input  logic             rst,
  hilo_div_ctrl_if.slave   bus
);

  state_t               state;
  logic [DATA_BITS-1:0] hi_q;
  logic [DATA_BITS-1:0] lo_q;
  logic [DATA_BITS-1:0] dividend_q;
  logic [DATA_BITS-1:0] divisor_q;
  logic                 sign_q;
  logic                 res_valid_q;
  logic                 dbz_q;
  logic                 ready;
  logic                 accept;

  assign ready  = (state == ST_IDLE) & ~bus.cancel;
  assign accept = bus.req_valid & ready;

  assign bus.req_ready    = ready;
  assign bus.busy         = (state != ST_IDLE);
  assign bus.res_valid    = res_valid_q;
  assign bus.dbz          = dbz_q;
  assign bus.hi           = hi_q;
  assign bus.lo           = lo_q;
  // Start is combinational so a flush in ISSUE suppresses it in the same cycle.
  assign bus.div_en       = (state == ST_ISSUE) & ~bus.cancel;
  assign bus.div_sign     = sign_q;
  assign bus.div_dividend = dividend_q;
  assign bus.div_divisor  = divisor_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      hi_q        <= '0;
      lo_q        <= '0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      sign_q      <= 1'b0;
      res_valid_q <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      res_valid_q <= 1'b0;
      dbz_q       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (op_is_move(bus.req_op)) begin
              if (bus.req_op == OP_MTHI) hi_q <= bus.req_a;
              else                       lo_q <= bus.req_a;
            end else if (bus.req_b == '0) begin
              hi_q        <= bus.req_a;
              lo_q        <= '1;
              res_valid_q <= 1'b1;
              dbz_q       <= 1'b1;
            end else begin
              dividend_q <= bus.req_a;
              divisor_q  <= bus.req_b;
              sign_q     <= ~bus.req_op[0];
              state      <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          state <= bus.cancel ? ST_IDLE : ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.div_done) begin
            // A flush landing on the completion cycle still discards the result.
            if (!bus.cancel) begin
              hi_q        <= bus.div_remainder;
              lo_q        <= bus.div_quotient;
              res_valid_q <= 1'b1;
            end
            state <= ST_IDLE;
          end else if (bus.cancel) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // The divider cannot be aborted, so wait out its completion.
          if (bus.div_done) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
